change_dispenser: RTL and testbench

- Sequential stage directly downstream of the coin-count parser. It takes the quarter/dime/nickel counts for one change transaction and drives the three coin-hopper solenoids one coin at a time.
- Each drop is confirmed by the chute sensor before the next coin is fired.
- It reports running cents paid, completion and jam status to the vending controller.

---
 rtl/coin_pkg.sv | 35 +++
 rtl/dispense_timer.sv | 27 ++
 rtl/change_dispenser.sv | 178 +++++++++++++++++
 tb/tb_change_dispenser.sv | 475 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coin_pkg.sv
// Shared types and constants for the change dispenser slice:
// FSM states, coin kinds and their cent values.
package coin_pkg;

    localparam int PAID_W = 10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_FIRE,
        S_WAIT_SENSE,
        S_GAP,
        S_FINISH,
        S_JAM
    } dispense_state_t;

    typedef enum logic [1:0] {
        COIN_Q,
        COIN_D,
        COIN_N
    } coin_t;

    localparam logic [PAID_W-1:0] VAL_Q = 10'd25;
    localparam logic [PAID_W-1:0] VAL_D = 10'd10;
    localparam logic [PAID_W-1:0] VAL_N = 10'd5;

    function automatic logic [PAID_W-1:0] coin_value(coin_t c);
        case (c)
            COIN_Q:  return VAL_Q;
            COIN_D:  return VAL_D;
            default: return VAL_N;
        endcase
    endfunction

endpackage

// File: rtl/dispense_timer.sv
// Loadable down-counter with a zero flag; shared by the pulse,
// sensor-timeout and settle phases of the dispenser.
module dispense_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    // Reload on request, otherwise count down and park at zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (count != '0)
            count <= count - W'(1);
    end

    assign zero = (count == '0);

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: fires quarter/dime/nickel solenoids one coin at
// a time, waits for the chute sensor and tallies cents paid.
module change_dispenser
    import coin_pkg::*;
#(
    parameter int PULSE_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int GAP_CYCLES     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [3:0]        q_in,
    input  logic [3:0]        d_in,
    input  logic [3:0]        n_in,
    input  logic              coin_sense,
    output logic              sol_q,
    output logic              sol_d,
    output logic              sol_n,
    output logic              busy,
    output logic              done,
    output logic              jam,
    output logic [PAID_W-1:0] paid
);

    localparam int TW = 16;

    dispense_state_t state;
    coin_t           sel;
    logic [3:0]      rem_q;
    logic [3:0]      rem_d;
    logic [3:0]      rem_n;
    logic            sensed;
    logic            in_window;
    logic            confirm;
    logic            captured;
    logic            t_load;
    logic [TW-1:0]   t_val;
    logic            t_zero;

    // Only the first sensor hit of a fire/wait window confirms a coin
    assign in_window = (state == S_FIRE) || (state == S_WAIT_SENSE);
    assign confirm   = in_window && coin_sense && !sensed && !abort;
    assign captured  = sensed || confirm;

    // Reload the phase timer on the edge that enters each timed state
    always_comb begin
        t_load = 1'b0;
        t_val  = '0;
        case (state)
            S_SELECT: begin
                t_load = 1'b1;
                t_val  = TW'(PULSE_CYCLES - 1);
            end
            S_FIRE: begin
                if (t_zero) begin
                    t_load = 1'b1;
                    t_val  = captured ? TW'(GAP_CYCLES - 1)
                                      : TW'(TIMEOUT_CYCLES - 1);
                end
            end
            S_WAIT_SENSE: begin
                if (coin_sense) begin
                    t_load = 1'b1;
                    t_val  = TW'(GAP_CYCLES - 1);
                end
            end
            default: ;
        endcase
    end

    dispense_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (t_load),
        .load_val (t_val),
        .zero     (t_zero)
    );

    // Main sequencer with registered solenoid and status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            sel    <= COIN_Q;
            rem_q  <= '0;
            rem_d  <= '0;
            rem_n  <= '0;
            sensed <= 1'b0;
            paid   <= '0;
            sol_q  <= 1'b0;
            sol_d  <= 1'b0;
            sol_n  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            jam    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (confirm) begin
                sensed <= 1'b1;
                paid   <= paid + coin_value(sel);
                case (sel)
                    COIN_Q:  rem_q <= rem_q - 4'd1;
                    COIN_D:  rem_d <= rem_d - 4'd1;
                    default: rem_n <= rem_n - 4'd1;
                endcase
            end
            if (abort) begin
                state <= S_IDLE;
                sol_q <= 1'b0;
                sol_d <= 1'b0;
                sol_n <= 1'b0;
                busy  <= 1'b0;
                jam   <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            rem_q <= q_in;
                            rem_d <= d_in;
                            rem_n <= n_in;
                            paid  <= '0;
                            busy  <= 1'b1;
                            state <= S_SELECT;
                        end
                    end
                    S_SELECT: begin
                        sensed <= 1'b0;
                        if (rem_q != '0) begin
                            sel   <= COIN_Q;
                            sol_q <= 1'b1;
                            state <= S_FIRE;
                        end else if (rem_d != '0) begin
                            sel   <= COIN_D;
                            sol_d <= 1'b1;
                            state <= S_FIRE;
                        end else if (rem_n != '0) begin
                            sel   <= COIN_N;
                            sol_n <= 1'b1;
                            state <= S_FIRE;
                        end else begin
                            done  <= 1'b1;
                            state <= S_FINISH;
                        end
                    end
                    S_FIRE: begin
                        if (t_zero) begin
                            sol_q <= 1'b0;
                            sol_d <= 1'b0;
                            sol_n <= 1'b0;
                            state <= captured ? S_GAP : S_WAIT_SENSE;
                        end
                    end
                    S_WAIT_SENSE: begin
                        if (coin_sense) begin
                            state <= S_GAP;
                        end else if (t_zero) begin
                            busy  <= 1'b0;
                            jam   <= 1'b1;
                            state <= S_JAM;
                        end
                    end
                    S_GAP: begin
                        if (t_zero)
                            state <= S_SELECT;
                    end
                    S_FINISH: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    S_JAM: ;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: directed scenarios plus
// randomized transactions against a transaction-level timing model.
module tb_change_dispenser;

    localparam int P = 4;
    localparam int T = 16;
    localparam int G = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       abort;
    logic [3:0] q_in;
    logic [3:0] d_in;
    logic [3:0] n_in;
    logic       coin_sense;
    logic       sol_q;
    logic       sol_d;
    logic       sol_n;
    logic       busy;
    logic       done;
    logic       jam;
    logic [9:0] paid;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;

    // schedule: sense offset after fire start (-1 none), hold, echo
    int sd[64];
    int hl[64];
    bit ex[64];

    // observations
    int         o_type[64];
    int         o_f[64];
    int         o_w[64];
    int         o_n;
    int         o_done_n;
    int         o_done_c;
    logic [9:0] o_done_paid;
    int         o_jam_c;
    logic [9:0] o_jam_paid;
    logic       o_jam_busy;
    logic       o_jam_end;
    bit         o_multi;
    bit         o_timeout;
    logic       o_busy_sel;
    logic       o_busy_after;
    int         k_start;

    // expectations
    int e_f[64];
    int e_done;
    int e_jam_idx;
    int e_jam_c;

    change_dispenser #(
        .PULSE_CYCLES   (P),
        .TIMEOUT_CYCLES (T),
        .GAP_CYCLES     (G)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .q_in       (q_in),
        .d_in       (d_in),
        .n_in       (n_in),
        .coin_sense (coin_sense),
        .sol_q      (sol_q),
        .sol_d      (sol_d),
        .sol_n      (sol_n),
        .busy       (busy),
        .done       (done),
        .jam        (jam),
        .paid       (paid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int exp_type(int i, int q, int d);
        if (i < q) return 0;
        if (i < q + d) return 1;
        return 2;
    endfunction

    function automatic int cents(int t);
        if (t == 0) return 25;
        if (t == 1) return 10;
        return 5;
    endfunction

    function automatic int exp_paid(int m, int q, int d);
        int s = 0;
        for (int i = 0; i < m; i++) s += cents(exp_type(i, q, d));
        return s;
    endfunction

    task automatic clear_sched();
        for (int i = 0; i < 64; i++) begin
            sd[i] = -1;
            hl[i] = 1;
            ex[i] = 1'b0;
        end
    endtask

    // Per coin: 1 select + P fire + wait + G gap; wait only if late
    task automatic model(input int q, input int d, input int n);
        int f;
        int w;
        f = k_start + 1;
        e_jam_idx = -1;
        e_jam_c = -1;
        e_done = -1;
        for (int i = 0; i < q + d + n; i++) begin
            e_f[i] = f;
            if (sd[i] < 0 || sd[i] + 1 - P > T) begin
                e_jam_idx = i;
                e_jam_c = f + P + T;
                return;
            end
            w = (sd[i] + 1 - P > 0) ? sd[i] + 1 - P : 0;
            f = f + P + w + G + 1;
        end
        e_done = f;
    endtask

    // Drives one transaction, acting as the chute sensor; records only
    task automatic run_txn(input int q, input int d, input int n,
                           input bit noise);
        int  s_on = -1;
        int  s_hold = 0;
        int  s_ex = -1;
        int  stop_at = -1;
        bit  prev = 1'b0;
        bit  any;
        bit  ended = 1'b0;
        o_n = 0;
        o_done_n = 0;
        o_done_c = -1;
        o_jam_c = -1;
        o_jam_end = 1'b0;
        o_multi = 1'b0;
        o_timeout = 1'b0;
        o_busy_after = 1'bx;
        @(negedge clk);
        q_in = 4'(q);
        d_in = 4'(d);
        n_in = 4'(n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k_start = cyc;
        o_busy_sel = busy;
        q_in = 4'd15;
        d_in = 4'd15;
        n_in = 4'd15;
        for (int b = 0; b < 3000; b++) begin
            any = sol_q | sol_d | sol_n;
            if (int'(sol_q) + int'(sol_d) + int'(sol_n) > 1) o_multi = 1'b1;
            if (any && !prev && o_n < 64) begin
                o_type[o_n] = sol_q ? 0 : (sol_d ? 1 : 2);
                o_f[o_n] = cyc;
                o_w[o_n] = 0;
                if (sd[o_n] >= 0) begin
                    s_on = cyc + sd[o_n];
                    s_hold = hl[o_n];
                    s_ex = ex[o_n] ? s_on + 2 : -1;
                end else begin
                    s_on = -1;
                    s_ex = -1;
                end
                o_n++;
            end
            if (any && o_n > 0) o_w[o_n-1]++;
            prev = any;
            if (done) begin
                o_done_n++;
                if (o_done_c < 0) begin
                    o_done_c = cyc;
                    o_done_paid = paid;
                    stop_at = cyc + 2;
                end
            end
            if (jam && o_jam_c < 0) begin
                o_jam_c = cyc;
                o_jam_paid = paid;
                o_jam_busy = busy;
                stop_at = cyc + 4;
            end
            if (o_done_c >= 0 && cyc == o_done_c + 1) o_busy_after = busy;
            if (cyc == stop_at) begin
                o_jam_end = jam;
                ended = 1'b1;
                break;
            end
            coin_sense = (s_on >= 0 && cyc >= s_on && cyc < s_on + s_hold)
                         || (cyc == s_ex);
            start = noise && (cyc == k_start + 3 || cyc == k_start + 5);
            @(negedge clk);
        end
        coin_sense = 1'b0;
        start = 1'b0;
        if (!ended) o_timeout = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        coin_sense = 1'b0;
        q_in = '0;
        d_in = '0;
        n_in = '0;
        repeat (3) @(negedge clk);
        n_total++;
        if ({sol_q, sol_d, sol_n, busy, done, jam} !== 6'b0)
            $display("FAIL reset_outs got=%b want=000000",
                     {sol_q, sol_d, sol_n, busy, done, jam});
        else n_pass++;
        n_total++;
        if (paid !== 10'd0) $display("FAIL reset_paid got=%0d want=0", paid);
        else n_pass++;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_zero();
        clear_sched();
        run_txn(0, 0, 0, 1'b0);
        model(0, 0, 0);
        n_total++;
        if (o_timeout || o_done_c != e_done)
            $display("FAIL zero_done_time got=%0d want=%0d", o_done_c, e_done);
        else n_pass++;
        n_total++;
        if (o_n != 0 || o_done_n != 1 || o_done_paid !== 10'd0)
            $display("FAIL zero_misc got coins=%0d dones=%0d paid=%0d want 0/1/0",
                     o_n, o_done_n, o_done_paid);
        else n_pass++;
        n_total++;
        if (o_busy_sel !== 1'b1 || o_busy_after !== 1'b0)
            $display("FAIL zero_busy got=%b%b want=10", o_busy_sel, o_busy_after);
        else n_pass++;
    endtask

    task automatic test_single_wait();
        clear_sched();
        sd[0] = P + 1;
        run_txn(1, 0, 0, 1'b0);
        model(1, 0, 0);
        n_total++;
        if (o_n != 1 || o_type[0] != 0 || o_w[0] != P || o_f[0] != e_f[0])
            $display("FAIL single_pulse got n=%0d type=%0d w=%0d f=%0d want 1/0/%0d/%0d",
                     o_n, o_type[0], o_w[0], o_f[0], P, e_f[0]);
        else n_pass++;
        n_total++;
        if (o_timeout || o_done_c != e_done || o_done_paid !== 10'd25)
            $display("FAIL single_done got t=%0d paid=%0d want t=%0d paid=25",
                     o_done_c, o_done_paid, e_done);
        else n_pass++;
    endtask

    task automatic test_order_in_fire();
        clear_sched();
        for (int i = 0; i < 4; i++) sd[i] = $urandom_range(P - 1, 0);
        run_txn(2, 1, 1, 1'b0);
        model(2, 1, 1);
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if (o_type[i] != exp_type(i, 2, 1) || o_f[i] != e_f[i] || o_w[i] != P)
                $display("FAIL order_coin%0d got type=%0d f=%0d w=%0d want %0d/%0d/%0d",
                         i, o_type[i], o_f[i], o_w[i], exp_type(i, 2, 1), e_f[i], P);
            else n_pass++;
        end
        n_total++;
        if (o_timeout || o_n != 4 || o_done_n != 1 || o_done_paid !== 10'd65
            || o_done_c != e_done || o_multi)
            $display("FAIL order_done got n=%0d dones=%0d paid=%0d t=%0d want 4/1/65/%0d",
                     o_n, o_done_n, o_done_paid, o_done_c, e_done);
        else n_pass++;
    endtask

    task automatic test_jam();
        clear_sched();
        run_txn(0, 1, 0, 1'b0);
        model(0, 1, 0);
        n_total++;
        if (o_n != 1 || o_type[0] != 1 || o_w[0] != P)
            $display("FAIL jam_pulse got n=%0d type=%0d w=%0d want 1/1/%0d",
                     o_n, o_type[0], o_w[0], P);
        else n_pass++;
        n_total++;
        if (o_timeout || o_jam_c != e_jam_c)
            $display("FAIL jam_time got=%0d want=%0d", o_jam_c, e_jam_c);
        else n_pass++;
        n_total++;
        if (o_jam_busy !== 1'b0 || o_jam_paid !== 10'd0 || o_jam_end !== 1'b1
            || o_done_n != 0)
            $display("FAIL jam_state got busy=%b paid=%0d held=%b dones=%0d want 0/0/1/0",
                     o_jam_busy, o_jam_paid, o_jam_end, o_done_n);
        else n_pass++;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_total++;
        if (jam !== 1'b0 || busy !== 1'b0 || paid !== 10'd0)
            $display("FAIL jam_abort got jam=%b busy=%b paid=%0d want 0/0/0",
                     jam, busy, paid);
        else n_pass++;
    endtask

    task automatic test_double_sense_busy_start();
        clear_sched();
        sd[0] = 0;
        hl[0] = 1;
        ex[0] = 1'b1;
        run_txn(0, 1, 0, 1'b1);
        model(0, 1, 0);
        n_total++;
        if (o_timeout || o_n != 1 || o_type[0] != 1 || o_done_paid !== 10'd10
            || o_done_c != e_done || o_done_n != 1)
            $display("FAIL double_sense got n=%0d paid=%0d t=%0d dones=%0d want 1/10/%0d/1",
                     o_n, o_done_paid, o_done_c, o_done_n, e_done);
        else n_pass++;
    endtask

    task automatic test_abort();
        int  rise = 0;
        int  dn = 0;
        bit  any_sol = 1'b0;
        @(negedge clk);
        q_in = 4'd3;
        d_in = 4'd0;
        n_in = 4'd0;
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (busy || sol_q || sol_d || sol_n) any_sol = 1'b1;
            @(negedge clk);
        end
        n_total++;
        if (any_sol || paid !== 10'd10)
            $display("FAIL abort_beats_start got active=%b paid=%0d want 0/10",
                     any_sol, paid);
        else n_pass++;
        q_in = 4'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 50 && rise == 0; i++) begin
            if (sol_q) rise = 1;
            else @(negedge clk);
        end
        n_total++;
        if (rise == 0) $display("FAIL abort_fire_wait got=no_pulse want=pulse");
        else n_pass++;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_total++;
        if (sol_q !== 1'b0 || busy !== 1'b0)
            $display("FAIL abort_fire got sol_q=%b busy=%b want 0/0", sol_q, busy);
        else n_pass++;
        for (int i = 0; i < 10; i++) begin
            if (done) dn++;
            @(negedge clk);
        end
        n_total++;
        if (dn != 0) $display("FAIL abort_no_done got=%0d want=0", dn);
        else n_pass++;
    endtask

    task automatic test_random();
        int q;
        int d;
        int n;
        for (int t = 0; t < 20; t++) begin
            q = $urandom_range(4, 0);
            d = $urandom_range(4, 0);
            n = $urandom_range(4, 0);
            clear_sched();
            for (int i = 0; i < q + d + n; i++) begin
                sd[i] = $urandom_range(P + T - 2, 0);
                hl[i] = $urandom_range(2, 1);
                ex[i] = 1'($urandom_range(1, 0));
            end
            run_txn(q, d, n, (q + d + n) > 0);
            model(q, d, n);
            n_total++;
            if (o_n != q + d + n || o_multi)
                $display("FAIL rand%0d_count got=%0d multi=%b want=%0d",
                         t, o_n, o_multi, q + d + n);
            else n_pass++;
            for (int i = 0; i < o_n && i < q + d + n; i++) begin
                n_total++;
                if (o_type[i] != exp_type(i, q, d) || o_f[i] != e_f[i] || o_w[i] != P)
                    $display("FAIL rand%0d_coin%0d got type=%0d f=%0d w=%0d want %0d/%0d/%0d",
                             t, i, o_type[i], o_f[i], o_w[i],
                             exp_type(i, q, d), e_f[i], P);
                else n_pass++;
            end
            n_total++;
            if (o_timeout || o_done_c != e_done || o_done_n != 1
                || o_done_paid !== 10'(exp_paid(q + d + n, q, d)))
                $display("FAIL rand%0d_done got t=%0d paid=%0d dones=%0d want t=%0d paid=%0d",
                         t, o_done_c, o_done_paid, o_done_n, e_done,
                         exp_paid(q + d + n, q, d));
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_fire();
        int  rises = 0;
        bit  pv = 1'b0;
        @(negedge clk);
        q_in = 4'd2;
        d_in = 4'd0;
        n_in = 4'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 200 && rises < 2; c++) begin
            @(negedge clk);
            coin_sense = 1'b0;
            if (sol_q && !pv) begin
                rises++;
                if (rises == 1) coin_sense = 1'b1;
            end
            pv = sol_q;
        end
        coin_sense = 1'b0;
        n_total++;
        if (rises < 2 || sol_q !== 1'b1 || paid !== 10'd25)
            $display("FAIL rst_pre got rises=%0d sol_q=%b paid=%0d want 2/1/25",
                     rises, sol_q, paid);
        else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_total++;
        if (sol_q !== 1'b0 || busy !== 1'b0 || paid !== 10'd0 || done !== 1'b0)
            $display("FAIL rst_async got sol_q=%b busy=%b paid=%0d done=%b want 0/0/0/0",
                     sol_q, busy, paid, done);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_total++;
        if (busy !== 1'b0 || sol_q !== 1'b0)
            $display("FAIL rst_idle got busy=%b sol_q=%b want 0/0", busy, sol_q);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_zero();
        test_single_wait();
        test_order_in_fire();
        test_jam();
        test_double_sense_busy_start();
        test_abort();
        test_random();
        test_reset_mid_fire();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
